// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default word width and depth used by the controller,
// RAM and read stage, plus the read-stage output buffer occupancy encoding.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  // Output buffer occupancy; encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_t s);
    case (s)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer (head + skid registers) with its occupancy FSM.
// Stream handshake: a word transfers at a rising edge where out_valid and
// out_ready are both high; out_valid never drops and out_data never changes
// until that transfer happens. in_valid marks a word that must be captured at
// this edge (no backpressure on the input side: the caller guarantees room).
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_t             occ
);

  occ_t             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = head_q;
  assign occ       = state_q;

  // Next-state and register routing; capture and pop together keep order by
  // sending the new word behind whatever remains after the pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_valid) begin
          head_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_valid && pop) begin
          head_d = in_data;
        end else if (in_valid) begin
          skid_d  = in_data;
          state_d = S_TWO;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // Capture without pop cannot happen here: the read stage never has
        // more than two words buffered or in flight.
        if (pop) begin
          head_d = skid_q;
          if (in_valid) begin
            skid_d = in_data;
          end else begin
            state_d = S_ONE;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and data registers; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_read_stage.sv
// FIFO read stage: issues pop pulses to the FIFO controller while there is room
// downstream, captures the RAM's registered read data one cycle later and
// presents it as a valid/ready stream (1 word/cycle sustained).
// Optional build macro FIFO_READ_STATS_EN adds delivered_count/underrun_seen.
module fifo_read_stage
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  input  logic [WIDTH-1:0] rd_data,
  output logic             read,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_READ_STATS_EN
  ,
  output logic [15:0]      delivered_count,
  output logic             underrun_seen
`endif
);

  logic       inflight_q;
  occ_t       occ;
  logic       pop;
  logic [2:0] level;

  assign pop   = out_valid & out_ready;
  // Words buffered plus the one the RAM is returning this cycle.
  assign level = {1'b0, occ_count(occ)} + {2'b00, inflight_q};

  // Read whenever the buffer can absorb the word, counting a same-cycle pop.
  always_comb begin
    read = ~reset & ~empty & ((level < 3'd2) | pop);
  end

  // A read sampled at this edge puts valid RAM data on rd_data next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= read;
    end
  end

  fifo_out_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

`ifdef FIFO_READ_STATS_EN
  // Delivered-word counter (wrapping) and sticky sink-starved flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      delivered_count <= 16'h0000;
      underrun_seen   <= 1'b0;
    end else begin
      if (pop) begin
        delivered_count <= delivered_count + 16'h0001;
      end
      if (out_ready && !out_valid) begin
        underrun_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_stage.sv
// Directed bench for fifo_read_stage with a RAM/controller model and an
// in-order scoreboard. Build with FIFO_READ_STATS_EN to also cover the stats.
module tb_fifo_read_stage;
  import fifo_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         empty = 1'b1;
  logic [W-1:0] rd_data = '0;
  logic         read;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef FIFO_READ_STATS_EN
  logic [15:0]  delivered_count;
  logic         underrun_seen;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] ram_q[$];
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_data = '0;

  logic [W-1:0] t2_exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [W-1:0] t3_exp[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  // Clock generation.
  always #5 clk = ~clk;

  fifo_read_stage #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .empty           (empty),
    .rd_data         (rd_data),
    .read            (read),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
`ifdef FIFO_READ_STATS_EN
    ,
    .delivered_count (delivered_count),
    .underrun_seen   (underrun_seen)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the current cycle (called just after a falling edge).
  task automatic drive(input logic rst, input logic e, input logic rdy);
    reset     = rst;
    empty     = e;
    out_ready = rdy;
    #1;
  endtask

  // Scoreboard/hold checks for this cycle, then step through the rising edge,
  // modelling the RAM's registered read port.
  task automatic advance();
    logic         do_read;
    logic [W-1:0] w;
    if (hold_pend && !reset) begin
      check("hold_valid", {15'd0, out_valid}, 16'd1);
      check("hold_data", {8'd0, out_data}, {8'd0, hold_data});
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_extra: observed word %h expected none", out_data);
      end else begin
        w = exp_q.pop_front();
        check("sb_order", {8'd0, out_data}, {8'd0, w});
      end
      pops++;
    end
    hold_pend = !reset && out_valid && !out_ready;
    hold_data = out_data;
    do_read   = read;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else if (do_read) begin
      if (ram_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL ram_underflow: observed read=1 expected read=0");
      end else begin
        w = ram_q.pop_front();
        rd_data = w;
        exp_q.push_back(w);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset for two cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      check("rst_read", {15'd0, read}, 16'd0);
      advance();
    end

    // Idle: empty FIFO, ready sink.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      check("idle_read", {15'd0, read}, 16'd0);
      check("idle_valid", {15'd0, out_valid}, 16'd0);
      if (i == 0) check("idle_data", {8'd0, out_data}, 16'd0);
      advance();
    end

    // Continuous stream of four words.
    ram_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i >= 4), 1'b1);
      check("strm_read", {15'd0, read}, {15'd0, (i < 4)});
      check("strm_valid", {15'd0, out_valid}, {15'd0, (i >= 2 && i < 6)});
      if (i >= 2 && i < 6) check("strm_data", {8'd0, out_data}, {8'd0, t2_exp[i-2]});
      advance();
    end
    check("strm_drained", 16'(exp_q.size()), 16'd0);

    // Backpressure: fill both entries, hold, then release.
    ram_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive(1'b0, 1'b0, 1'b0);
    check("bp_read0", {15'd0, read}, 16'd1);
    advance();
    drive(1'b0, 1'b0, 1'b0);
    check("bp_read1", {15'd0, read}, 16'd1);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      check("bp_hold_read", {15'd0, read}, 16'd0);
      check("bp_hold_valid", {15'd0, out_valid}, 16'd1);
      check("bp_hold_data", {8'd0, out_data}, 16'h0011);
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (i >= 3), 1'b1);
      check("bp_rel_read", {15'd0, read}, {15'd0, (i < 3)});
      check("bp_rel_valid", {15'd0, out_valid}, {15'd0, (i < 5)});
      if (i < 5) check("bp_rel_data", {8'd0, out_data}, {8'd0, t3_exp[i]});
      advance();
    end

    // Empty rises right after a read: in-flight word still delivered.
    ram_q = '{8'h5A};
    drive(1'b0, 1'b0, 1'b1);
    check("emp_read0", {15'd0, read}, 16'd1);
    advance();
    drive(1'b0, 1'b1, 1'b1);
    check("emp_read1", {15'd0, read}, 16'd0);
    check("emp_valid1", {15'd0, out_valid}, 16'd0);
    advance();
    drive(1'b0, 1'b1, 1'b1);
    check("emp_read2", {15'd0, read}, 16'd0);
    check("emp_valid2", {15'd0, out_valid}, 16'd1);
    check("emp_data2", {8'd0, out_data}, 16'h005A);
    advance();
    drive(1'b0, 1'b1, 1'b1);
    check("emp_valid3", {15'd0, out_valid}, 16'd0);
    advance();

    // Reset with one word buffered and one in flight.
    ram_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    drive(1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b1);
    check("rst1_read", {15'd0, read}, 16'd0);
    check("rst1_pre_data", {8'd0, out_data}, 16'h0061);
    advance();
    ram_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      check("rst1_valid", {15'd0, out_valid}, 16'd0);
      check("rst1_read", {15'd0, read}, 16'd0);
      check("rst1_data", {8'd0, out_data}, 16'd0);
      advance();
    end

    // Reset with both entries full.
    ram_q = '{8'h71, 8'h72};
    drive(1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b1, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b1);
    check("rst2_read", {15'd0, read}, 16'd0);
    advance();
    ram_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      check("rst2_valid", {15'd0, out_valid}, 16'd0);
      check("rst2_data", {8'd0, out_data}, 16'd0);
      advance();
    end

    // Random traffic with random sink stalls.
    for (int i = 0; i < 300; i++) begin
      if (ram_q.size() < 3 && $urandom_range(0, 1) == 1) ram_q.push_back(W'($urandom_range(0, 255)));
      drive(1'b0, (ram_q.size() == 0), ($urandom_range(0, 3) != 0));
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (ram_q.size() == 0), 1'b1);
      advance();
    end
    check("rand_drained", 16'(exp_q.size() + ram_q.size()), 16'd0);
    check("rand_valid", {15'd0, out_valid}, 16'd0);

`ifdef FIFO_READ_STATS_EN
    drive(1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 1'b1, 1'b0);
    check("st_cnt_rst", delivered_count, 16'd0);
    check("st_und_rst", {15'd0, underrun_seen}, 16'd0);
    for (int i = 0; i < 65537; i++) ram_q.push_back(W'(i));
    pops = 0;
    for (int c = 0; c < 70000 && pops < 65537; c++) begin
      drive(1'b0, (ram_q.size() == 0), out_valid);
      advance();
    end
    drive(1'b0, 1'b1, 1'b0);
    check("st_pops", 16'(pops - 65537), 16'd0);
    check("st_cnt_wrap", delivered_count, 16'd1);
    check("st_und_clear", {15'd0, underrun_seen}, 16'd0);
    advance();
    drive(1'b0, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b1, 1'b0);
    check("st_und_set", {15'd0, underrun_seen}, 16'd1);
    advance();
    drive(1'b0, 1'b1, 1'b0);
    check("st_und_hold", {15'd0, underrun_seen}, 16'd1);
    advance();
    drive(1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 1'b1, 1'b0);
    check("st_und_reset", {15'd0, underrun_seen}, 16'd0);
    check("st_cnt_reset", delivered_count, 16'd0);
    advance();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
